tick_scheduler: RTL
===================

# tick_scheduler

Multi-channel tick-enable scheduler driven by the 100 MHz system clock. A shared prescaler produces a 1 MHz base tick. Per-channel programmable counters derive slower one-cycle tick enables from it, so game logic and peripherals run as clock enables instead of on divided clocks. Channel configuration uses a valid/ready handshake and takes effect only on a base-tick boundary, so no channel ever sees a partial period.

## Interface
- PRESCALE, 100, inclk cycles per base tick (≥2)
- NUM_CH, 4, number of tick channels (≥1)
- PW, 16, channel period register width
- CW, max(1,$clog2(NUM_CH)), channel-select width (derived)

Ports:
- inclk  input  1  system clock, 100 MHz; all logic on its rising edge
- rst  input  1  reset, synchronous, active-low
- cfg_valid  input  1  configuration request
- cfg_ready  output  1  scheduler can accept a configuration
- cfg_ch  input  CW  target channel
- cfg_period  input  PW  period in base ticks
- cfg_en  input  1  channel enable
- base_tick  output  1  one-cycle pulse every PRESCALE cycles
- tick  output  NUM_CH  per-channel one-cycle tick enables
- sq_out  output  NUM_CH  per-channel square wave (present only with TICK_SQUARE_OUT_EN)

## Operation
- Prescaler `pcnt` counts 0..PRESCALE-1.
  - A "wrap edge" is an edge where `pcnt`==PRESCALE-1. On it, `pcnt` goes to 0 and base_tick is registered to 1.
  - base_tick is 0 on every other edge.
- Each channel holds `en`, `period[PW]` and `ccnt[PW]`.
  - Effective enable is `en && period!=0`, so period 0 means disabled.
- On a wrap edge, each effectively enabled channel updates as follows:
  - If `ccnt`==period-1: `ccnt`←0 and tick[i]←1.
  - Otherwise: `ccnt`++ and tick[i]←0.
- Disabled channels hold `ccnt`=0 and tick[i]=0. tick[i] is 0 on every non-wrap edge.
- Configuration FSM:
  - IDLE: cfg_ready=1. On cfg_valid&&cfg_ready, capture ch/period/en and go to PEND.
  - PEND: cfg_ready=0. On the next wrap edge, apply the captured values to the channel, force its `ccnt`←0 and tick←0, then go to IDLE.
- Applying a configuration to a running channel restarts its phase. The old schedule produces no further ticks.
- A cfg_ch ≥ NUM_CH is accepted and then dropped at the apply edge; no state changes.
- An accept on an edge that is itself a wrap edge applies at the following wrap edge.
- Width rules:
  - `pcnt` has $clog2(PRESCALE) bits.
  - Channel compare is full-width PW.
  - cfg_period=1 gives a tick on every base tick.
  - Max period is 2^PW−1.

## Timing
- Reset values: base_tick=0, tick=0, sq_out=0, cfg_ready=1, FSM=IDLE, `pcnt`=0, all channels disabled with period=0 and `ccnt`=0.
- Edge numbering: the first rising edge with rst=1 is edge 1. The first wrap edge is edge PRESCALE, then every PRESCALE edges after that.
- Output registration and duration:
  - base_tick and tick are registered.
  - Each is high for exactly one cycle following its wrap edge.
  - tick[i] always coincides with base_tick.
- Handshake latency:
  - Accept to apply takes 1..PRESCALE edges.
  - cfg_ready rises on the apply edge, so the next accept is possible one cycle later.
- The first tick after an apply occurs on the P-th wrap edge following the apply edge.
- Reset mid-operation (rst=0 sampled on any edge):
  - All state returns to reset values on that edge.
  - A pending configuration is discarded.

## Configuration
- Macro: TICK_SQUARE_OUT_EN.
- Defined:
  - sq_out[i] toggles on every edge where tick[i] is set, giving a 50 % duty wave with a period of 2·P base ticks.
  - It is cleared to 0 at apply and held while the channel is disabled.
- Undefined: the sq_out port and its registers do not exist. All other behaviour is identical.

## Test plan
All scenarios use PRESCALE=100, NUM_CH=4, PW=16.
1. Release reset, apply no config → base_tick high after edges 100, 200, 300; tick=0; cfg_ready=1 throughout.
2. Accept ch0/period 3/en 1 at edge 10 → cfg_ready=0 on edges 11–100; apply at 100; tick[0] after edges 400, 700, 1000 only.
3. Hold cfg_valid for ch1/period 1 from edge 50 while ch0 is pending → ch1 accepted at edge 101, applied at 200; tick[1] after edges 300, 400, 500.
4. With ch0 running at period 3, accept period 5 at edge 450 → apply at 500; no tick[0] at 700; tick[0] after 1000 and 1500.
5. Accept ch2 with period 0 and en 1 → never ticks; cfg_ready returns to 1 after the apply edge.
6. Accept ch3/period 2 at edge 120, drive rst=0 at edge 150, release at edge 160 → all outputs 0 and cfg_ready=1; ch3 never ticks. With TICK_SQUARE_OUT_EN and scenario 2, sq_out[0] rises at 400 and falls at 700.

Source files
------------

// File: rtl/tick_scheduler.sv
// tick_scheduler
//   Multi-channel tick-enable scheduler. A shared prescaler divides the system
//   clock into a base tick; each channel counts base ticks and emits a
//   one-cycle tick enable every `period` base ticks. Channel configuration is
//   accepted over a valid/ready handshake and applied only on a base-tick
//   boundary, so a channel never runs a partial period.
//
//   Optional feature macro: TICK_SQUARE_OUT_EN adds the sq_out port, a
//   per-channel square wave that toggles on every tick of that channel.
//
// Ports
//   inclk       system clock, all logic on its rising edge
//   rst         synchronous reset, active low
//   cfg_valid   configuration request
//   cfg_ready   scheduler can accept a configuration (registered)
//   cfg_ch      target channel (out-of-range values are accepted then dropped)
//   cfg_period  period in base ticks (0 disables the channel)
//   cfg_en      channel enable
//   base_tick   one-cycle pulse every PRESCALE cycles (registered)
//   tick        per-channel one-cycle tick enables (registered)
//   sq_out      per-channel square wave (TICK_SQUARE_OUT_EN only)
module tick_scheduler #(
  parameter int PRESCALE = 100,
  parameter int NUM_CH   = 4,
  parameter int PW       = 16,
  parameter int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              inclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CW-1:0]     cfg_ch,
  input  logic [PW-1:0]     cfg_period,
  input  logic              cfg_en,
  output logic              base_tick,
  output logic [NUM_CH-1:0] tick
`ifdef TICK_SQUARE_OUT_EN
  ,
  output logic [NUM_CH-1:0] sq_out
`endif
);

  localparam int             PCW       = $clog2(PRESCALE);
  localparam logic [PCW-1:0] PCNT_LAST = PCW'(PRESCALE - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  logic [PCW-1:0]    pcnt_q, pcnt_d;
  logic              base_tick_q, base_tick_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [PW-1:0]     period_q [NUM_CH];
  logic [PW-1:0]     period_d [NUM_CH];
  logic [PW-1:0]     ccnt_q   [NUM_CH];
  logic [PW-1:0]     ccnt_d   [NUM_CH];
  state_e            state_q, state_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic [CW-1:0]     cap_ch_q, cap_ch_d;
  logic [PW-1:0]     cap_period_q, cap_period_d;
  logic              cap_en_q, cap_en_d;
`ifdef TICK_SQUARE_OUT_EN
  logic [NUM_CH-1:0] sq_q, sq_d;
`endif

  logic              wrap_s;
  logic              apply_s;
  logic [NUM_CH-1:0] eff_en_s;
  logic [NUM_CH-1:0] apply_hit_s;

  // Prescaler: wrap edge is the last count; base_tick pulses after it.
  always_comb begin
    wrap_s      = (pcnt_q == PCNT_LAST);
    base_tick_d = wrap_s;
    if (wrap_s) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PCW'(1);
    end
  end

  // Configuration handshake: capture in IDLE, apply on the next wrap edge.
  always_comb begin
    state_d      = state_q;
    cfg_ready_d  = cfg_ready_q;
    cap_ch_d     = cap_ch_q;
    cap_period_d = cap_period_q;
    cap_en_d     = cap_en_q;
    apply_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid && cfg_ready_q) begin
          cap_ch_d     = cfg_ch;
          cap_period_d = cfg_period;
          cap_en_d     = cfg_en;
          state_d      = ST_PEND;
          cfg_ready_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        // An accept that landed on a wrap edge waits for the following one,
        // because PEND is only entered after that edge.
        if (wrap_s) begin
          apply_s     = 1'b1;
          state_d     = ST_IDLE;
          cfg_ready_d = 1'b1;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cfg_ready_d = 1'b1;
      end
    endcase
  end

  // Per-channel effective enable and apply target decode.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      eff_en_s[i]    = en_q[i] && (period_q[i] != '0);
      // Channel numbers >= NUM_CH match no index, so such configs are dropped.
      apply_hit_s[i] = apply_s && (cap_ch_q == CW'(i));
    end
  end

  // Channel counters: apply restarts phase, otherwise count on wrap edges.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      en_d[i]     = en_q[i];
      period_d[i] = period_q[i];
      ccnt_d[i]   = ccnt_q[i];
      tick_d[i]   = 1'b0;
      if (apply_hit_s[i]) begin
        en_d[i]     = cap_en_q;
        period_d[i] = cap_period_q;
        ccnt_d[i]   = '0;
      end else if (wrap_s && eff_en_s[i]) begin
        if (ccnt_q[i] == (period_q[i] - PW'(1))) begin
          ccnt_d[i] = '0;
          tick_d[i] = 1'b1;
        end else begin
          ccnt_d[i] = ccnt_q[i] + PW'(1);
        end
      end else if (!eff_en_s[i]) begin
        ccnt_d[i] = '0;
      end else begin
        ccnt_d[i] = ccnt_q[i];
      end
    end
  end

`ifdef TICK_SQUARE_OUT_EN
  // Square wave: toggle per tick, cleared at apply and while disabled.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sq_d[i] = sq_q[i];
      if (apply_hit_s[i]) begin
        sq_d[i] = 1'b0;
      end else if (tick_d[i]) begin
        sq_d[i] = ~sq_q[i];
      end else if (!eff_en_s[i]) begin
        sq_d[i] = 1'b0;
      end else begin
        sq_d[i] = sq_q[i];
      end
    end
  end
`endif

  // State registers with synchronous active-low reset.
  always_ff @(posedge inclk) begin
    if (!rst) begin
      pcnt_q       <= '0;
      base_tick_q  <= 1'b0;
      tick_q       <= '0;
      en_q         <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i] <= '0;
        ccnt_q[i]   <= '0;
      end
      state_q      <= ST_IDLE;
      cfg_ready_q  <= 1'b1;
      cap_ch_q     <= '0;
      cap_period_q <= '0;
      cap_en_q     <= 1'b0;
`ifdef TICK_SQUARE_OUT_EN
      sq_q         <= '0;
`endif
    end else begin
      pcnt_q       <= pcnt_d;
      base_tick_q  <= base_tick_d;
      tick_q       <= tick_d;
      en_q         <= en_d;
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i] <= period_d[i];
        ccnt_q[i]   <= ccnt_d[i];
      end
      state_q      <= state_d;
      cfg_ready_q  <= cfg_ready_d;
      cap_ch_q     <= cap_ch_d;
      cap_period_q <= cap_period_d;
      cap_en_q     <= cap_en_d;
`ifdef TICK_SQUARE_OUT_EN
      sq_q         <= sq_d;
`endif
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign base_tick = base_tick_q;
  assign tick      = tick_q;
`ifdef TICK_SQUARE_OUT_EN
  assign sq_out    = sq_q;
`endif

endmodule
